// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: a registered one-hot grant selects which master drives the shared slave port.
// A stalled strobed beat that waits too long for ack is ended with a one-cycle err to its owner.
module wb_rr_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int TIMEOUT   = 255,
    parameter int TO_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_MASTERS-1:0]    m_cyc_i,
    input  logic [N_MASTERS-1:0]    m_stb_i,
    input  logic [N_MASTERS-1:0]    m_we_i,
    input  logic [4*N_MASTERS-1:0]  m_sel_i,
    input  logic [32*N_MASTERS-1:0] m_adr_i,
    input  logic [32*N_MASTERS-1:0] m_dat_i,
    output logic [31:0]             m_dat_o,
    output logic [N_MASTERS-1:0]    m_ack_o,
    output logic [N_MASTERS-1:0]    m_err_o,
    output logic [N_MASTERS-1:0]    grant_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [3:0]              s_sel_o,
    output logic [31:0]             s_adr_o,
    output logic [31:0]             s_dat_o,
    input  logic [31:0]             s_dat_i,
    input  logic                    s_ack_i
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    localparam logic [IDX_W:0]   SUM_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W:0]   SUM_N   = (IDX_W+1)'(N_MASTERS);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_MASTERS - 1);
    localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;

    logic [2*N_MASTERS-1:0] req_dbl;
    logic [N_MASTERS-1:0]   req_rot;
    logic [IDX_W-1:0]       pick_off;
    logic [IDX_W:0]         pick_sum;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_vld;

    logic                   st_own;
    logic                   busy;
    logic                   own_cyc;
    logic                   own_stb;

    // last_q doubles as the owner index whenever grant_q is non-zero.
    assign st_own  = (state_q == ST_OWN);
    assign busy    = |grant_q;
    assign own_cyc = m_cyc_i[last_q];
    assign own_stb = m_stb_i[last_q];

    // Rotate requests so bit 0 is master (last+1) mod N, then take the lowest set bit.
    always_comb begin
        req_dbl  = {m_cyc_i, m_cyc_i};
        req_rot  = N_MASTERS'(req_dbl >> ({1'b0, last_q} + SUM_ONE));
        pick_vld = |m_cyc_i;
        pick_off = '0;
        for (int j = N_MASTERS - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                pick_off = IDX_W'(j);
            end
        end
        pick_sum = {1'b0, last_q} + {1'b0, pick_off} + SUM_ONE;
        if (pick_sum >= SUM_N) begin
            pick_sum = pick_sum - SUM_N;
        end
        pick_idx = IDX_W'(pick_sum);
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (pick_vld) begin
                    state_d = ST_OWN;
                    grant_d = N_MASTERS'(1) << pick_idx;
                    last_d  = pick_idx;
                end
            end
            ST_OWN: begin
                // Release takes priority; an ack in the limit cycle still wins over err.
                if (!own_cyc) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    to_cnt_d = '0;
                end else if (s_ack_i || !own_stb) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LIM) begin
                    state_d  = ST_ERR;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end
            ST_ERR: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                to_cnt_d = '0;
            end
            default: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                to_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            last_q   <= LAST_RST;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign grant_o = grant_q;
    assign s_cyc_o = st_own & own_cyc;
    assign s_stb_o = st_own & own_stb;
    assign s_we_o  = busy & m_we_i[last_q];
    assign s_sel_o = busy ? m_sel_i[{last_q, 2'b00} +: 4] : 4'h0;
    assign s_adr_o = busy ? m_adr_i[{last_q, 5'b00000} +: 32] : 32'h0;
    assign s_dat_o = busy ? m_dat_i[{last_q, 5'b00000} +: 32] : 32'h0;
    assign m_ack_o = (st_own && s_ack_i) ? grant_q : '0;
    assign m_err_o = (state_q == ST_ERR) ? grant_q : '0;
    assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios plus random traffic, all compared every cycle
// against a transaction-level owner/priority model.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int TO = 255;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
    logic [4*N-1:0]    m_sel_i;
    logic [32*N-1:0]   m_adr_i, m_dat_i;
    logic [31:0]       m_dat_o;
    logic [N-1:0]      m_ack_o, m_err_o, grant_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]        s_sel_o;
    logic [31:0]       s_adr_o, s_dat_o, s_dat_i;
    logic              s_ack_i;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.N_MASTERS(N), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .reset(reset),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_sel_i(m_sel_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .grant_o(grant_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: who owns the bus, whether it is in its error cycle,
    // who was served last, and how many counted stall cycles the beat has.
    int own;
    int last;
    int stall;
    bit in_err;

    logic [N-1:0] obs_grant, obs_ack, obs_err;
    logic         obs_scyc, obs_sstb;

    function automatic void model_reset();
        own = -1; last = N - 1; stall = 0; in_err = 1'b0;
    endfunction

    function automatic void model_next();
        if (in_err) begin
            own = -1; in_err = 1'b0; stall = 0;
        end else if (own >= 0) begin
            if (!m_cyc_i[own]) begin
                own = -1; stall = 0;
            end else if (s_ack_i || !m_stb_i[own]) begin
                stall = 0;
            end else if (stall == TO) begin
                in_err = 1'b1; stall = 0;
            end else begin
                stall++;
            end
        end else begin
            for (int i = 1; i <= N; i++) begin
                if (own < 0 && m_cyc_i[(last + i) % N]) begin
                    own  = (last + i) % N;
                    last = own;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        logic [N-1:0] oh;
        bit act;
        oh = '0;
        if (own >= 0) oh[own] = 1'b1;
        act = (own >= 0) && !in_err;
        chk("grant",  grant_o, oh);
        chk("s_cyc",  s_cyc_o, act ? m_cyc_i[own] : 1'b0);
        chk("s_stb",  s_stb_o, act ? m_stb_i[own] : 1'b0);
        chk("s_we",   s_we_o,  (own >= 0) ? m_we_i[own] : 1'b0);
        chk("s_sel",  s_sel_o, (own >= 0) ? m_sel_i[own*4 +: 4] : 4'h0);
        chk("s_adr",  s_adr_o, (own >= 0) ? m_adr_i[own*32 +: 32] : 32'h0);
        chk("s_dat",  s_dat_o, (own >= 0) ? m_dat_i[own*32 +: 32] : 32'h0);
        chk("m_ack",  m_ack_o, (act && s_ack_i) ? oh : '0);
        chk("m_err",  m_err_o, in_err ? oh : '0);
        chk("m_dat",  m_dat_o, s_dat_i);
        obs_grant = grant_o; obs_ack = m_ack_o; obs_err = m_err_o;
        obs_scyc  = s_cyc_o; obs_sstb = s_stb_o;
    endtask

    // Entered at a falling edge with inputs already driven; leaves at the next falling edge.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_next();
        @(negedge clk);
    endtask

    task automatic do_reset();
        m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0;
        reset = 1'b1;
        #2;
        chk("rst_grant", grant_o, '0);
        chk("rst_s_cyc", s_cyc_o, 1'b0);
        chk("rst_s_stb", s_stb_o, 1'b0);
        chk("rst_ack_err", {m_ack_o, m_err_o}, '0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic rand_inputs();
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) == 0) m_cyc_i[k] = ~m_cyc_i[k];
            m_adr_i[k*32 +: 32] = $urandom;
            m_dat_i[k*32 +: 32] = $urandom;
        end
        m_stb_i = N'($urandom);
        m_we_i  = N'($urandom);
        m_sel_i = (4*N)'($urandom);
        s_dat_i = $urandom;
        s_ack_i = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        int acks, guard, stb_cycles, gcount;
        bit err_seen, done, beat_now;
        logic [N-1:0] err_val, prev_g;
        logic [N-1:0] gseq [5];

        reset = 1'b1;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '0;
        m_dat_i = '0; s_dat_i = '0; s_ack_i = 1'b0;
        for (int k = 0; k < N; k++) m_adr_i[k*32 +: 32] = 32'h1000_0000 + 32'(k) * 32'h100;
        model_reset();
        @(negedge clk);

        // 1: three-beat burst from master 0, slave acks two cycles after each strobe
        do_reset();
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001; acks = 0;
        step();
        for (int b = 0; b < 3; b++) begin
            s_ack_i = 1'b0; step();
            if (b == 0) chk("t1_grant_after_req", obs_grant, 4'b0001);
            step();
            s_ack_i = 1'b1; step();
            acks += int'(obs_ack[0]);
        end
        s_ack_i = 1'b0; m_stb_i = '0; m_cyc_i = '0;
        step();
        chk("t1_grant_held_drop_cycle", obs_grant, 4'b0001);
        step();
        chk("t1_grant_released", obs_grant, 4'b0000);
        chk("t1_ack_count", acks, 3);

        // 2: everyone requests; each owner does one beat and drops cyc for a cycle
        do_reset();
        m_stb_i = 4'b1111; s_ack_i = 1'b1; done = 1'b0; gcount = 0; prev_g = '0;
        for (int c = 0; c < 30; c++) begin
            m_cyc_i = 4'b1111;
            if (own >= 0 && done) m_cyc_i[own] = 1'b0;
            beat_now = (own >= 0) && !in_err && m_cyc_i[own];
            step();
            if (obs_grant != 0 && obs_grant != prev_g && gcount < 5) begin
                gseq[gcount] = obs_grant; gcount++;
            end
            prev_g = obs_grant;
            if (beat_now) done = 1'b1;
            if (own < 0) done = 1'b0;
        end
        chk("t2_grant_count", gcount, 5);
        chk("t2_seq0", gseq[0], 4'b0001);
        chk("t2_seq1", gseq[1], 4'b0010);
        chk("t2_seq2", gseq[2], 4'b0100);
        chk("t2_seq3", gseq[3], 4'b1000);
        chk("t2_seq4", gseq[4], 4'b0001);

        // 3: master 2 owns, master 1 asks mid-transfer and must wait
        do_reset();
        s_ack_i = 1'b0; m_stb_i = 4'b0110;
        m_cyc_i = 4'b0100; step(); step();
        m_cyc_i = 4'b0110; repeat (5) step();
        chk("t3_no_preempt", obs_grant, 4'b0100);
        m_cyc_i = 4'b0010; step(); step();
        step();
        chk("t3_handover", obs_grant, 4'b0010);
        chk("t3_adr_switch", s_adr_o, m_adr_i[1*32 +: 32]);

        // 4: slave never acks; the registered count is compared, so the beat stalls TO+1 cycles
        do_reset();
        m_cyc_i = 4'b0011; m_stb_i = 4'b0011; s_ack_i = 1'b0;
        stb_cycles = 0; err_seen = 1'b0; guard = 0; err_val = '0;
        while (!err_seen && guard < 400) begin
            step();
            if (obs_sstb) stb_cycles++;
            if (|obs_err) begin
                err_seen = 1'b1; err_val = obs_err;
                chk("t4_cyc_low_in_err", obs_scyc, 1'b0);
            end
            guard++;
        end
        chk("t4_err_seen", err_seen, 1'b1);
        chk("t4_stall_cycles", stb_cycles, TO + 1);
        chk("t4_err_owner", err_val, 4'b0001);
        step();
        chk("t4_err_one_cycle", obs_err, 4'b0000);
        step();
        chk("t4_next_requester", obs_grant, 4'b0010);

        // 5: ack arrives exactly when the stall count hits TIMEOUT
        do_reset();
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001; s_ack_i = 1'b0; guard = 0;
        while (!(own >= 0 && stall == TO) && guard < 400) begin
            step(); guard++;
        end
        chk("t5_reached_limit", guard < 400, 1'b1);
        s_ack_i = 1'b1; step();
        chk("t5_ack", obs_ack, 4'b0001);
        chk("t5_no_err", obs_err, 4'b0000);
        s_ack_i = 1'b0; err_seen = 1'b0;
        repeat (20) begin
            step();
            if (|obs_err) err_seen = 1'b1;
        end
        chk("t5_counter_cleared", err_seen, 1'b0);

        // 6: reset while master 3 is mid-beat releases the bus immediately
        do_reset();
        m_cyc_i = 4'b1000; m_stb_i = 4'b1000; s_ack_i = 1'b0;
        step(); step();
        s_ack_i = 1'b1;
        #1;
        chk("t6_pre_owner", grant_o, 4'b1000);
        reset = 1'b1;
        #1;
        chk("t6_async_grant", grant_o, 4'b0000);
        chk("t6_async_cyc", s_cyc_o, 1'b0);
        chk("t6_async_ack", m_ack_o, 4'b0000);
        m_cyc_i = 4'b1001; s_ack_i = 1'b0;
        #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        model_next();
        @(negedge clk);
        step();
        chk("t6_master0_first", obs_grant, 4'b0001);

        // random traffic
        do_reset();
        repeat (3000) begin
            rand_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
